mux_frame_collector: RTL

Sequential collector for the board's time-multiplexed key-select datapath. It drives the select lines of a `NR_KEY`-way, `DATA_LEN`-bit multiplexer and samples the multiplexer output once per key. It then reassembles the `NR_KEY*DATA_LEN`-bit source word and hands it downstream with a valid/ready handshake. In the board top it sits between the multiplexer output and the LED/register stage, and recovers all keyed fields from the narrow output.

---
 rtl/mux_frame_if.sv | 25 ++
 rtl/mux_frame_collector.sv | 116 +++++++++++
 2 files changed

// File: rtl/mux_frame_if.sv
// Handshake and datapath bundle between the frame collector and its keyed
// multiplexer source / downstream consumer.
interface mux_frame_if #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2
) ();
  logic                         start;
  logic [KEY_LEN-1:0]           sel;
  logic [DATA_LEN-1:0]          din;
  logic [NR_KEY*DATA_LEN-1:0]   frame;
  logic                         frame_valid;
  logic                         frame_ready;
  logic                         busy;

  modport master (
    input  start, din, frame_ready,
    output sel, frame, frame_valid, busy
  );

  modport slave (
    output start, din, frame_ready,
    input  sel, frame, frame_valid, busy
  );
endinterface

// File: rtl/mux_frame_collector.sv
// Steps the select lines of a keyed multiplexer, samples each slot after a
// settle delay and presents the reassembled word with a valid/ready handshake.
module mux_frame_collector #(
  parameter int NR_KEY     = 4,
  parameter int KEY_LEN    = 2,
  parameter int DATA_LEN   = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux_frame_if.master bus
);
  localparam int FW    = NR_KEY * DATA_LEN;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [KEY_LEN-1:0] LAST_KEY = KEY_LEN'(NR_KEY - 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [KEY_LEN-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]      shadow_q, shadow_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic               sample_en;
  logic               clear_shadow;
  logic               load_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    sample_en    = 1'b0;
    clear_shadow = 1'b0;
    load_frame   = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (bus.start) begin
          state_d      = DRIVE;
          cnt_d        = '0;
          clear_shadow = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        sample_en = 1'b1;
        if (sel_q == LAST_KEY) begin
          state_d    = DONE;
          load_frame = 1'b1;
        end else begin
          sel_d   = sel_q + KEY_LEN'(1);
          state_d = DRIVE;
        end
      end
      DONE: begin
        if (bus.frame_ready) begin
          sel_d = '0;
          // A start coinciding with the transfer chains straight into the next frame.
          if (bus.start) begin
            state_d      = DRIVE;
            cnt_d        = '0;
            clear_shadow = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-slot shadow update; the final slot is merged before the frame copy.
  generate
    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_slot
      always_comb begin
        if (clear_shadow)
          shadow_d[gi*DATA_LEN +: DATA_LEN] = '0;
        else if (sample_en && (sel_q == KEY_LEN'(gi)))
          shadow_d[gi*DATA_LEN +: DATA_LEN] = bus.din;
        else
          shadow_d[gi*DATA_LEN +: DATA_LEN] = shadow_q[gi*DATA_LEN +: DATA_LEN];
      end
    end
  endgenerate

  assign frame_d = load_frame ? shadow_d : frame_q;

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
endmodule
